// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32 fetch stage and its consumers (decode reuses if_id_t).
package fetch_stage_pkg;

  // Canonical RV32 no-op: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FETCH: idle, WAIT: response wanted, DROP: response will be discarded
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // IF/ID pipeline register contents; RV32 only, so fields are 32 bits wide
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// One-entry buffer that parks an imem response while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            consume,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  // Occupancy flag: clear beats load, load beats consume
  always_ff @(posedge clk) begin
    if (rst)          valid <= 1'b0;
    else if (clear)   valid <= 1'b0;
    else if (load)    valid <= 1'b1;
    else if (consume) valid <= 1'b0;
  end

  // Payload capture on load
  // NOTE: payload is not reset; it is only ever read while valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: PC generation, single-outstanding imem handshake and
// the IF/ID register. Optional macro FETCH_PERF_CNT_EN adds the two
// performance counters; without it both counter outputs are tied to zero.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_if,
  input  logic            stall_id,
  input  logic            flush_branch,
  input  logic            flush_jump,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;   // address of the request currently outstanding
  if_id_t          id_q;

  logic            redirect;
  logic            issue;
  logic            resp_ok;
  logic            hold_valid;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;

  assign redirect = flush_branch | flush_jump;

  // A new request may leave when nothing is outstanding, or when the
  // outstanding one returns in this very cycle.
  assign issue = !rst && !redirect && !stall_if && !stall_id && !hold_valid &&
                 ((state_q == FETCH) || (state_q == WAIT && imem_rvalid));

  // Response that is wanted and not killed by a redirect this cycle
  assign resp_ok = (state_q == WAIT) && imem_rvalid && !redirect;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (resp_ok && stall_id),
    .consume    (!redirect && !stall_id && hold_valid),
    .clear      (redirect),
    .load_pc    (req_pc_q),
    .load_instr (imem_rdata),
    .valid      (hold_valid),
    .pc         (hold_pc),
    .instr      (hold_instr)
  );

  // PC and request-tracking state machine
  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      state_q  <= FETCH;
    end else begin
      if (issue) req_pc_q <= pc_q;

      if (redirect)   pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (issue) pc_q <= pc_q + XLEN'(4);

      case (state_q)
        FETCH: if (issue) state_q <= WAIT;
        WAIT: begin
          if (redirect)         state_q <= imem_rvalid ? FETCH : DROP;
          else if (imem_rvalid) state_q <= issue ? WAIT : FETCH;
        end
        DROP:    if (imem_rvalid) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  // IF/ID register: redirect > stall > held response > fresh response > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
    end else if (redirect) begin
      id_q.valid <= 1'b0;
      id_q.instr <= NOP_INSTR;
    end else if (stall_id) begin
      id_q <= id_q;
    end else if (hold_valid) begin
      id_q <= '{valid: 1'b1, pc: hold_pc, pc_plus4: hold_pc + 32'd4, instr: hold_instr};
    end else if (resp_ok) begin
      id_q <= '{valid: 1'b1, pc: req_pc_q, pc_plus4: req_pc_q + 32'd4, instr: imem_rdata};
    end else begin
      id_q.valid <= 1'b0;
      id_q.instr <= NOP_INSTR;
    end
  end

  assign id_valid    = id_q.valid;
  assign id_pc       = id_q.pc;
  assign id_pc_plus4 = id_q.pc_plus4;
  assign id_instr    = id_q.instr;

`ifdef FETCH_PERF_CNT_EN
  logic id_load;
  assign id_load = !redirect && !stall_id && (hold_valid || resp_ok);

  // Free-running delivery and bubble counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (id_load)                  perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (!id_q.valid && !stall_id) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: variable-latency memory model plus a
// scoreboard of instructions that decode should receive, in order.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_if, stall_id, flush_branch, flush_jump;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .flush_branch   (flush_branch),
    .flush_jump     (flush_jump),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  bit          mem_pend = 1'b0;
  int          mem_due  = 0;
  logic [31:0] mem_addr = '0;
  int          mem_epoch = 0;
  int          epoch    = 0;
  logic [31:0] exp_fetch = '0;
  int          n_deliv  = 0;
  logic        smp_req, smp_valid;
  logic [31:0] smp_addr, smp_pc;
  int          m_fetch = 0, m_bubble = 0;
  bit          prev_live = 1'b0, prev_sd = 1'b0, prev_red = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Sampled at the falling edge: scoreboard, memory bookkeeping, request checks
  task automatic observe();
    logic red;
    exp_t e;
    red       = flush_branch | flush_jump;
    smp_req   = imem_req;
    smp_addr  = imem_addr;
    smp_valid = id_valid;
    smp_pc    = id_pc;

    if (!id_valid) begin
      check("id_nop_when_invalid", id_instr, NOP);
    end else if (!stall_id && !red) begin
      if (exp_q.size() == 0) begin
        check("id_unexpected_instr", {31'b0, id_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_instr", id_instr, e.instr);
        check("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        n_deliv++;
      end
    end

    if (imem_rvalid) begin
      mem_pend = 1'b0;
      if (!red && mem_epoch == epoch) begin
        e.pc = mem_addr;
        e.instr = instr_of(mem_addr);
        exp_q.push_back(e);
      end
    end

    if (red) begin
      epoch++;
      exp_q.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end

    if (stall_if || stall_id || red) check("blocked_no_req", {31'b0, imem_req}, 32'd0);

    if (imem_req) begin
      check("single_outstanding", {31'b0, mem_pend}, 32'd0);
      check("imem_addr_seq", imem_addr, exp_fetch);
      exp_fetch += 32'd4;
      mem_pend  = 1'b1;
      mem_addr  = imem_addr;
      mem_due   = cyc + (rand_lat ? int'($urandom_range(1, 5)) : lat);
      mem_epoch = epoch;
    end

`ifdef FETCH_PERF_CNT_EN
    if (prev_live && !prev_sd && !prev_red && id_valid) m_fetch++;
    check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    check("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
    if (!id_valid && !stall_id) m_bubble++;
`endif
    prev_live = 1'b1;
    prev_sd   = stall_id;
    prev_red  = red;
  endtask

  // One clock cycle: drive inputs, sample at negedge, advance past posedge
  task automatic tick(input logic bf, input logic bj, input logic si, input logic sd,
                      input logic [31:0] rpc);
    flush_branch = bf;
    flush_jump   = bj;
    stall_if     = si;
    stall_id     = sd;
    redirect_pc  = rpc;
    imem_rvalid  = mem_pend && (cyc >= mem_due);
    imem_rdata   = imem_rvalid ? instr_of(mem_addr) : 32'hDEAD_BEEF;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got_req, got_valid;

    rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush_branch = 1'b0;
    flush_jump = 1'b0; redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'd0);
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_bubble", perf_bubble_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset release with 1-cycle memory
    lat = 1;
    tick(0, 0, 0, 0, 0);
    check("t1_first_req", {31'b0, smp_req}, 32'd1);
    check("t1_addr0", smp_addr, 32'h0);
    tick(0, 0, 0, 0, 0);
    check("t1_addr4", smp_addr, 32'h4);
    tick(0, 0, 0, 0, 0);
    check("t1_addr8", smp_addr, 32'h8);
    check("t1_id_valid", {31'b0, smp_valid}, 32'd1);
    check("t1_id_pc0", smp_pc, 32'h0);
    repeat (5) begin
      tick(0, 0, 0, 0, 0);
      check("t1_steady_valid", {31'b0, smp_valid}, 32'd1);
    end

    // 2: both stalls for 3 cycles with a response in flight
    repeat (3) begin
      tick(0, 0, 1, 1, 0);
      check("t2_no_req", {31'b0, smp_req}, 32'd0);
      check("t2_frozen_valid", {31'b0, smp_valid}, 32'd1);
      if (exp_q.size() > 0) check("t2_frozen_pc", smp_pc, exp_q[0].pc);
    end
    tick(0, 0, 0, 0, 0);
    check("t2_release_no_req", {31'b0, smp_req}, 32'd0);
    tick(0, 0, 0, 0, 0);
    check("t2_held_appears", {31'b0, smp_valid}, 32'd1);
    repeat (4) tick(0, 0, 0, 0, 0);

    // 3: branch redirect to 0x100 with a 3-cycle request outstanding
    lat = 3;
    repeat (6) tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && !(mem_pend && cyc < mem_due); i++) tick(0, 0, 0, 0, 0);
    check("t3_setup_outstanding", {31'b0, (mem_pend && cyc < mem_due)}, 32'd1);
    tick(1, 0, 0, 0, 32'h100);
    got_req = 1'b0; got_valid = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      tick(0, 0, 0, 0, 0);
      if (smp_req && !got_req) begin
        check("t3_redirect_addr", smp_addr, 32'h100);
        got_req = 1'b1;
      end
      if (smp_valid) begin
        check("t3_first_pc", smp_pc, 32'h100);
        got_valid = 1'b1;
      end
    end
    check("t3_arrived", {31'b0, got_valid}, 32'd1);

    // 4: jump with stall_id and a full hold buffer, misaligned target
    lat = 1;
    repeat (4) tick(0, 0, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 32'h103);
    got_req = 1'b0; got_valid = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      tick(0, 0, 0, 0, 0);
      if (smp_req && !got_req) begin
        check("t4_redirect_addr", smp_addr, 32'h100);
        got_req = 1'b1;
      end
      if (smp_valid) begin
        check("t4_first_pc", smp_pc, 32'h100);
        got_valid = 1'b1;
      end
    end
    check("t4_arrived", {31'b0, got_valid}, 32'd1);

    // 5: random latency, stalls and redirects
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           32'($urandom_range(0, 1023)));
    end
    repeat (30) tick(0, 0, 1, 0, 0);
    check("t5_no_loss", exp_q.size(), 32'd0);
    check("t5_none_outstanding", {31'b0, mem_pend}, 32'd0);
    check("t5_progress", {31'b0, n_deliv > 50}, 32'd1);

`ifndef FETCH_PERF_CNT_EN
    check("perf_fetch_tied0", perf_fetch_cnt, 32'd0);
    check("perf_bubble_tied0", perf_bubble_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
